ex_stage: RTL and testbench

- Execute stage of the 5-stage pipeline, directly downstream of the decode stage.
- Consumes decoded operands, immediate, destination register, opcode and the rs/rt forwarding selects.
- Resolves forwarding, computes the ALU result or effective address, and evaluates BEQ.
- Registers everything into the EX/MEM boundary; an optional iterative multiplier stalls upstream while busy.

---
 rtl/ex_stage_pkg.sv | 43 ++++
 rtl/ex_mul_iter.sv | 64 ++++++
 rtl/ex_stage.sv | 130 +++++++++++++
 tb/tb_ex_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: opcodes, forward selects,
// multiplier FSM states, the EX/MEM register layout and the operand mux.
package ex_stage_pkg;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_SLT  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h06;
    localparam logic [5:0] OP_LDW  = 6'h07;
    localparam logic [5:0] OP_SDW  = 6'h08;
    localparam logic [5:0] OP_BEQ  = 6'h09;
    localparam logic [5:0] OP_JUMP = 6'h0A;
    localparam logic [5:0] OP_MUL  = 6'h0B;

    localparam logic [2:0] FWD_REG = 3'd0;
    localparam logic [2:0] FWD_EX  = 3'd1;
    localparam logic [2:0] FWD_WB  = 3'd2;

    typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] res;
        logic [31:0] rt;
        logic [4:0]  rwd;
        logic [5:0]  opcode;
        logic        taken;
    } ex_out_t;

    // Unused select codes fall back to the register-file value.
    function automatic logic [31:0] fwd_sel(input logic [2:0] sel, input logic [31:0] rf,
                                            input logic [31:0] ex, input logic [31:0] wb);
        case (sel)
            FWD_EX:  return ex;
            FWD_WB:  return wb;
            default: return rf;
        endcase
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per BUSY cycle, then a
// single DONE cycle presenting the low 32 bits of the product.
module ex_mul_iter
    import ex_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        idle,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    mul_state_t  state_q, state_d;
    logic [31:0] a_q, b_q, acc_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MUL_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (start) state_d = MUL_BUSY;
            MUL_BUSY: if (cnt_q == CW'(MUL_CYCLES - 1)) state_d = MUL_DONE;
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == MUL_IDLE && start) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == MUL_BUSY) begin
            if (b_q[0]) acc_q <= acc_q + a_q;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign idle   = (state_q == MUL_IDLE);
    assign busy   = (state_q == MUL_BUSY);
    assign done   = (state_q == MUL_DONE);
    assign result = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU / address / BEQ evaluation and the
// EX/MEM register. Define MUL_EN to build in the iterative multiplier.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] imm_in,
    input  logic [31:0] val_rs_in,
    input  logic [31:0] val_rt_in,
    input  logic [4:0]  rwd_in,
    input  logic [5:0]  opcode_in,
    input  logic [2:0]  rs_fwd,
    input  logic [2:0]  rt_fwd,
    input  logic [31:0] wb_fwd_in,
    output logic        stall_out,
    output logic        out_valid,
    output logic [31:0] alu_res_out,
    output logic [31:0] val_rt_out,
    output logic [4:0]  rwd_out,
    output logic [5:0]  opcode_out,
    output logic        branch_taken
);

    logic [31:0] op_a, op_b, alu_res, last_res;
    logic        taken;
    ex_out_t     nxt;

    assign op_a = fwd_sel(rs_fwd, val_rs_in, last_res, wb_fwd_in);
    assign op_b = fwd_sel(rt_fwd, val_rt_in, last_res, wb_fwd_in);

    always_comb begin
        alu_res = '0;
        taken   = 1'b0;
        case (opcode_in)
            OP_ADD:                  alu_res = op_a + op_b;
            OP_SUB:                  alu_res = op_a - op_b;
            OP_AND:                  alu_res = op_a & op_b;
            OP_OR:                   alu_res = op_a | op_b;
            OP_SLT:                  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_ADDI, OP_LDW, OP_SDW: alu_res = op_a + imm_in;
            OP_BEQ: begin
                alu_res = op_a - op_b;
                taken   = (op_a == op_b);
            end
            default:                 alu_res = '0;
        endcase
    end

`ifdef MUL_EN
    logic        mul_start, mul_idle, mul_busy, mul_done;
    logic [31:0] mul_res, cap_rt;
    logic [4:0]  cap_rwd;

    // Stall rises combinationally in the accept cycle so decode holds the MUL.
    assign mul_start = in_valid && (opcode_in == OP_MUL) && mul_idle;
    assign stall_out = mul_start || mul_busy;

    ex_mul_iter #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (op_a),
        .b      (op_b),
        .idle   (mul_idle),
        .busy   (mul_busy),
        .done   (mul_done),
        .result (mul_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_rt  <= '0;
            cap_rwd <= '0;
        end else if (mul_start) begin
            cap_rt  <= op_b;
            cap_rwd <= rwd_in;
        end
    end
`else
    assign stall_out = 1'b0;
`endif

    always_comb begin
        nxt = '0;
`ifdef MUL_EN
        // DONE wins over the still-held MUL on the inputs.
        if (mul_done) begin
            nxt.valid  = 1'b1;
            nxt.res    = mul_res;
            nxt.rt     = cap_rt;
            nxt.rwd    = cap_rwd;
            nxt.opcode = OP_MUL;
        end else if (in_valid && !stall_out) begin
`else
        if (in_valid) begin
`endif
            nxt.valid  = 1'b1;
            nxt.res    = alu_res;
            nxt.rt     = op_b;
            nxt.rwd    = rwd_in;
            nxt.opcode = opcode_in;
            nxt.taken  = taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            alu_res_out  <= '0;
            val_rt_out   <= '0;
            rwd_out      <= '0;
            opcode_out   <= OP_NOP;
            branch_taken <= 1'b0;
            last_res     <= '0;
        end else begin
            out_valid    <= nxt.valid;
            alu_res_out  <= nxt.res;
            val_rt_out   <= nxt.rt;
            rwd_out      <= nxt.rwd;
            opcode_out   <= nxt.opcode;
            branch_taken <= nxt.taken;
            if (nxt.valid && nxt.rwd != 5'd0) last_res <= nxt.res;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Randomised bench for ex_stage against a cycle-level behavioural model,
// plus directed literal checks for forwarding, SLT/BEQ, MUL and reset.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam int MC = 32;
`ifdef MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] imm_in = '0, val_rs_in = '0, val_rt_in = '0, wb_fwd_in = '0;
    logic [4:0]  rwd_in = '0;
    logic [5:0]  opcode_in = '0;
    logic [2:0]  rs_fwd = '0, rt_fwd = '0;
    logic        stall_out, out_valid, branch_taken;
    logic [31:0] alu_res_out, val_rt_out;
    logic [4:0]  rwd_out;
    logic [5:0]  opcode_out;

    ex_stage #(.MUL_CYCLES(MC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .imm_in(imm_in),
        .val_rs_in(val_rs_in), .val_rt_in(val_rt_in), .rwd_in(rwd_in),
        .opcode_in(opcode_in), .rs_fwd(rs_fwd), .rt_fwd(rt_fwd),
        .wb_fwd_in(wb_fwd_in), .stall_out(stall_out), .out_valid(out_valid),
        .alu_res_out(alu_res_out), .val_rt_out(val_rt_out), .rwd_out(rwd_out),
        .opcode_out(opcode_out), .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0, stall_seen = 0;
    bit chk_en = 1'b0;

    // model state
    logic        e_valid = 0, e_taken = 0;
    logic [31:0] e_res = 0, e_rt = 0, m_last = 0, m_prod = 0, m_rt = 0;
    logic [4:0]  e_rwd = 0, m_rwd = 0;
    logic [5:0]  e_op = 0;
    int          m_k = 0;   // cycles since MUL accepted, 0 when none

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [31:0] fwd(input logic [2:0] s, input logic [31:0] rf);
        if (s == 3'd1) return m_last;
        if (s == 3'd2) return wb_fwd_in;
        return rf;
    endfunction

    task automatic bubble();
        e_valid = 0; e_res = 0; e_rt = 0; e_rwd = 0; e_op = OP_NOP; e_taken = 0;
    endtask

    // model: what the EX/MEM register must hold after each edge
    initial begin
        logic [31:0] a, b, r;
        logic t;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                bubble(); m_last = 0; m_k = 0;
            end else if (m_k >= 1 && m_k <= MC) begin
                bubble(); m_k++;
            end else if (m_k == MC + 1) begin
                e_valid = 1; e_res = m_prod; e_rt = m_rt; e_rwd = m_rwd; e_op = OP_MUL; e_taken = 0;
                if (m_rwd != 0) m_last = m_prod;
                m_k = 0;
            end else if (!in_valid) begin
                bubble();
            end else begin
                a = fwd(rs_fwd, val_rs_in);
                b = fwd(rt_fwd, val_rt_in);
                if (MUL_ON && opcode_in == OP_MUL) begin
                    m_prod = a * b; m_rt = b; m_rwd = rwd_in; m_k = 1;
                    bubble();
                end else begin
                    t = 0;
                    case (opcode_in)
                        OP_ADD: r = a + b;
                        OP_SUB: r = a - b;
                        OP_AND: r = a & b;
                        OP_OR:  r = a | b;
                        OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        OP_ADDI, OP_LDW, OP_SDW: r = a + imm_in;
                        OP_BEQ: begin r = a - b; t = (a == b); end
                        default: r = 0;
                    endcase
                    e_valid = 1; e_res = r; e_rt = b; e_rwd = rwd_in; e_op = opcode_in; e_taken = t;
                    if (rwd_in != 0) m_last = r;
                end
            end
        end
    end

    // per-cycle compare, mid-cycle
    initial begin
        logic exp_stall;
        forever begin
            @(negedge clk);
            if (stall_out) stall_seen++;
            if (rst_n && chk_en) begin
                exp_stall = MUL_ON && ((m_k == 0 && in_valid && opcode_in == OP_MUL) ||
                                       (m_k >= 1 && m_k <= MC));
                chk("stall_out", 32'(stall_out), 32'(exp_stall));
                chk("out_valid", 32'(out_valid), 32'(e_valid));
                chk("alu_res_out", alu_res_out, e_res);
                chk("val_rt_out", val_rt_out, e_rt);
                chk("rwd_out", 32'(rwd_out), 32'(e_rwd));
                chk("opcode_out", 32'(opcode_out), 32'(e_op));
                chk("branch_taken", 32'(branch_taken), 32'(e_taken));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (m_k != 0 && n < 200) begin @(posedge clk); #1; n++; end
        if (m_k != 0) begin
            n_tot++;
            $display("FAIL mul_timeout: still busy after %0d cycles", n);
        end
    endtask

    task automatic issue(input logic v, input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic [4:0] rwd, input logic [2:0] rsf,
                         input logic [2:0] rtf, input logic [31:0] wb);
        in_valid = v; opcode_in = op; val_rs_in = rs; val_rt_in = rt; imm_in = imm;
        rwd_in = rwd; rs_fwd = rsf; rt_fwd = rtf; wb_fwd_in = wb;
        @(posedge clk); #1;
        wait_idle();
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 7));
            1: return $urandom;
            2: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return 32'h1234;
        endcase
    endfunction

    initial begin
        int s0;
        logic [31:0] exp_mul;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst alu_res", alu_res_out, 32'd0);
        chk("rst rwd_out", 32'(rwd_out), 32'd0);
        chk("rst opcode_out", 32'(opcode_out), 32'(OP_NOP));
        chk("rst stall", 32'(stall_out), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        issue(1, OP_ADD, 5, 7, 0, 3, 0, 0, 0);
        chk("add res", alu_res_out, 32'd12);
        chk("add rwd", 32'(rwd_out), 32'd3);
        chk("add valid", 32'(out_valid), 32'd1);
        issue(1, OP_SUB, 0, 2, 0, 0, 1, 0, 0);
        chk("sub fwd_ex", alu_res_out, 32'd10);
        issue(1, OP_SUB, 0, 2, 0, 0, 2, 0, 100);
        chk("sub fwd_wb", alu_res_out, 32'd98);
        issue(1, OP_SLT, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0);
        chk("slt signed", alu_res_out, 32'd1);
        issue(1, OP_BEQ, 32'h1234, 32'h1234, 0, 0, 0, 0, 0);
        chk("beq eq taken", 32'(branch_taken), 32'd1);
        chk("beq eq res", alu_res_out, 32'd0);
        chk("beq eq rwd", 32'(rwd_out), 32'd0);
        issue(1, OP_BEQ, 32'h1234, 32'h1235, 0, 0, 0, 0, 0);
        chk("beq ne taken", 32'(branch_taken), 32'd0);

        exp_mul = MUL_ON ? 32'h0005_000F : 32'd0;
        s0 = stall_seen;
        issue(1, OP_MUL, 32'h0001_0003, 32'h0000_0005, 0, 4, 0, 0, 0);
        chk("mul stall cycles", 32'(stall_seen - s0), MUL_ON ? 32'(MC + 1) : 32'd0);
        chk("mul valid", 32'(out_valid), 32'd1);
        chk("mul res", alu_res_out, exp_mul);
        issue(1, OP_ADD, 0, 0, 0, 1, 1, 0, 0);
        chk("add after mul", alu_res_out, exp_mul);

        // reset in the middle of a multiply
        in_valid = 1; opcode_in = OP_MUL; val_rs_in = 9; val_rt_in = 9; rwd_in = 2;
        rs_fwd = 0; rt_fwd = 0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst valid", 32'(out_valid), 32'd0);
        chk("midrst res", alu_res_out, 32'd0);
        chk("midrst stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(1, OP_ADD, 1, 1, 0, 0, 0, 0, 0);
        chk("add after rst", alu_res_out, 32'd2);

        for (int i = 0; i < 400; i++) begin
            issue($urandom_range(0, 9) < 8, 6'($urandom_range(0, 15)), rv(), rv(), rv(),
                  5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rv());
        end

        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
